nts_rx_buffer: RTL and testbench

Double-buffered packet receive store between the NTS dispatcher FIFO and the NTS packet parser. Copies one packet at a time from the dispatcher FIFO into one of two BRAM banks, then computes its exact byte length from the last-word valid mask. It publishes the filled bank to the parser through a synchronous read port and a ready/release handshake. While the parser works on one bank, the next packet is copied into the other; oversize and empty packets are drained and dropped.

---
 rtl/nts_rx_buffer.sv | 240 ++++++++++++++++++++++++
 tb/tb_nts_rx_buffer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nts_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : nts_rx_buffer
// Purpose  : Double-buffered packet receive store between the NTS dispatcher
//            FIFO (first-word-fall-through) and the NTS packet parser. One
//            packet at a time is copied into one of two banks. Its exact byte
//            length comes from the last-word valid mask. The filled bank is
//            then handed to the parser through a synchronous read port and a
//            ready/release handshake. Oversize and empty packets are drained
//            and dropped without being published.
// Ports    : i_clk, i_areset (async, active-high)
//            dispatcher side : i_dispatch_packet_available, i_dispatch_data_valid,
//                              i_dispatch_fifo_empty, i_dispatch_fifo_rd_data,
//                              o_dispatch_fifo_rd_en, o_dispatch_packet_read_discard
//            parser side     : o_pkt_ready, o_pkt_bytes, i_rd_addr, o_rd_data,
//                              i_pkt_release
//            status          : o_busy, o_stat_packets, o_stat_overflows, o_stat_empty
// Options  : NTS_RX_BUFFER_STATS_EN enables the three statistics counters;
//            without it the counter ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module nts_rx_buffer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                                           i_clk,
    input  logic                                           i_areset,
    output logic                                           o_busy,
    input  logic                                           i_dispatch_packet_available,
    output logic                                           o_dispatch_packet_read_discard,
    input  logic [DATA_WIDTH/8-1:0]                        i_dispatch_data_valid,
    input  logic                                           i_dispatch_fifo_empty,
    output logic                                           o_dispatch_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]                          i_dispatch_fifo_rd_data,
    output logic                                           o_pkt_ready,
    output logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8):0]       o_pkt_bytes,
    input  logic [ADDR_WIDTH-1:0]                          i_rd_addr,
    output logic [DATA_WIDTH-1:0]                          o_rd_data,
    input  logic                                           i_pkt_release,
    output logic [31:0]                                    o_stat_packets,
    output logic [31:0]                                    o_stat_overflows,
    output logic [31:0]                                    o_stat_empty
);

    localparam int BPW     = DATA_WIDTH / 8;
    localparam int BB      = $clog2(BPW);
    localparam int BYTES_W = ADDR_WIDTH + BB + 1;
    localparam int DEPTH   = 1 << ADDR_WIDTH;

    // Word count of a bank that is already completely filled.
    localparam logic [ADDR_WIDTH:0] WCNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COPY    = 2'd1,
        S_DRAIN   = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [1:0]           full_q, full_d;
    logic [BYTES_W-1:0]   bytes_q [2];
    logic [ADDR_WIDTH:0]  wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                 w_wr_en;
    logic                 w_publish;
    logic [ADDR_WIDTH:0]  w_wcnt_m1;
    logic [BYTES_W-1:0]   w_valid_cnt;
    logic [BYTES_W-1:0]   w_pkt_bytes;

    // Two banks back to back; the bank select is the address MSB.
    logic [DATA_WIDTH-1:0] mem [0:2*DEPTH-1];

    // ------------------------------------------------------------------
    // Byte length of the packet being completed: all words but the last
    // are full, the last contributes its valid-byte count.
    // ------------------------------------------------------------------
    always_comb begin
        w_valid_cnt = '0;
        for (int i = 0; i < BPW; i++) begin
            w_valid_cnt = w_valid_cnt + BYTES_W'(i_dispatch_data_valid[i]);
        end
    end

    assign w_wcnt_m1   = wcnt_q - 1'b1;
    assign w_pkt_bytes = (BYTES_W'(w_wcnt_m1) << BB) + w_valid_cnt;

    // ------------------------------------------------------------------
    // Copy state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        wcnt_d    = wcnt_q;
        w_wr_en   = 1'b0;
        w_publish = 1'b0;
        case (state_q)
            S_IDLE: begin
                wcnt_d = '0;
                if (i_dispatch_packet_available && !full_q[wr_bank_q]) begin
                    // A packet with no words is acknowledged but never published.
                    state_d = i_dispatch_fifo_empty ? S_DISCARD : S_COPY;
                end
            end
            S_COPY: begin
                if (!i_dispatch_fifo_empty) begin
                    if (wcnt_q == WCNT_FULL) begin
                        state_d = S_DRAIN;
                    end else begin
                        w_wr_en = 1'b1;
                        wcnt_d  = wcnt_q + 1'b1;
                    end
                end else begin
                    w_publish = 1'b1;
                    wr_bank_d = ~wr_bank_q;
                    state_d   = S_DISCARD;
                end
            end
            S_DRAIN: begin
                if (i_dispatch_fifo_empty) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Completion and release always address different banks, so both
    // updates can be applied in the same cycle.
    always_comb begin
        full_d    = full_q;
        rd_bank_d = rd_bank_q;
        if (w_publish) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (i_pkt_release && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q    <= S_IDLE;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= 2'b00;
            wcnt_q     <= '0;
            bytes_q[0] <= '0;
            bytes_q[1] <= '0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            wcnt_q    <= wcnt_d;
            if (w_publish) begin
                bytes_q[wr_bank_q] <= w_pkt_bytes;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: write port from the copy engine, registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            mem[{wr_bank_q, wcnt_q[ADDR_WIDTH-1:0]}] <= i_dispatch_fifo_rd_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[{rd_bank_q, i_rd_addr}];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_dispatch_fifo_rd_en          = ((state_q == S_COPY) || (state_q == S_DRAIN))
                                            && !i_dispatch_fifo_empty;
    assign o_dispatch_packet_read_discard = (state_q == S_DISCARD);
    assign o_busy                         = (state_q != S_IDLE) || (&full_q);
    assign o_pkt_ready                    = full_q[rd_bank_q];
    assign o_pkt_bytes                    = bytes_q[rd_bank_q];
    assign o_rd_data                      = rd_data_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef NTS_RX_BUFFER_STATS_EN
    logic        w_ovf_evt;
    logic        w_empty_evt;
    logic [31:0] stat_packets_q;
    logic [31:0] stat_overflows_q;
    logic [31:0] stat_empty_q;

    assign w_ovf_evt   = (state_q == S_COPY) && (state_d == S_DRAIN);
    assign w_empty_evt = (state_q == S_IDLE) && (state_d == S_DISCARD);

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            stat_packets_q   <= '0;
            stat_overflows_q <= '0;
            stat_empty_q     <= '0;
        end else begin
            if (w_publish) begin
                stat_packets_q <= stat_packets_q + 32'd1;
            end
            if (w_ovf_evt) begin
                stat_overflows_q <= stat_overflows_q + 32'd1;
            end
            if (w_empty_evt) begin
                stat_empty_q <= stat_empty_q + 32'd1;
            end
        end
    end

    assign o_stat_packets   = stat_packets_q;
    assign o_stat_overflows = stat_overflows_q;
    assign o_stat_empty     = stat_empty_q;
`else
    assign o_stat_packets   = '0;
    assign o_stat_overflows = '0;
    assign o_stat_empty     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nts_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nts_rx_buffer
// Purpose  : Self-checking bench for nts_rx_buffer (ADDR_WIDTH=4, 64-bit).
//            A dispatcher/FIFO environment feeds packets, a parser
//            environment reads and releases banks, and a packet-level timeline
//            model predicts every output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nts_rx_buffer;

    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int BPW   = 8;
    localparam int DEPTH = 16;
    localparam int BW    = AW + 3 + 1;
    localparam int MAXP  = 64;
    localparam int MAXW  = 24;
`ifdef NTS_RX_BUFFER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_areset;
    logic          o_busy;
    logic          i_dispatch_packet_available;
    logic          o_dispatch_packet_read_discard;
    logic [7:0]    i_dispatch_data_valid;
    logic          i_dispatch_fifo_empty;
    logic          o_dispatch_fifo_rd_en;
    logic [DW-1:0] i_dispatch_fifo_rd_data;
    logic          o_pkt_ready;
    logic [BW-1:0] o_pkt_bytes;
    logic [AW-1:0] i_rd_addr;
    logic [DW-1:0] o_rd_data;
    logic          i_pkt_release;
    logic [31:0]   o_stat_packets, o_stat_overflows, o_stat_empty;

    always #5 clk = ~clk;

    nts_rx_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk                          (clk),
        .i_areset                       (i_areset),
        .o_busy                         (o_busy),
        .i_dispatch_packet_available    (i_dispatch_packet_available),
        .o_dispatch_packet_read_discard (o_dispatch_packet_read_discard),
        .i_dispatch_data_valid          (i_dispatch_data_valid),
        .i_dispatch_fifo_empty          (i_dispatch_fifo_empty),
        .o_dispatch_fifo_rd_en          (o_dispatch_fifo_rd_en),
        .i_dispatch_fifo_rd_data        (i_dispatch_fifo_rd_data),
        .o_pkt_ready                    (o_pkt_ready),
        .o_pkt_bytes                    (o_pkt_bytes),
        .i_rd_addr                      (i_rd_addr),
        .o_rd_data                      (o_rd_data),
        .i_pkt_release                  (i_pkt_release),
        .o_stat_packets                 (o_stat_packets),
        .o_stat_overflows               (o_stat_overflows),
        .o_stat_empty                   (o_stat_empty)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- packet store ----------------
    logic [DW-1:0] pw [MAXP][MAXW];
    int            plen [MAXP];
    logic [7:0]    pval [MAXP];
    int            npkts;

    task automatic add_pkt(input int len, input logic [7:0] val, input logic [63:0] base);
        plen[npkts] = len;
        pval[npkts] = val;
        for (int k = 0; k < MAXW; k++)
            pw[npkts][k] = (base != 0) ? base + 64'(k) : {$urandom, $urandom};
        npkts++;
    endtask

    function automatic int pbytes(input int p);
        return (plen[p] - 1) * BPW + $countones(pval[p]);
    endfunction

    // ---------------- environment ----------------
    bit            disp_active;
    int            gap, rd_ptr, disp_idx, pop_count, avail_start, last_disc;
    int            par_rel_pct, par_fixed_addr;
    bit            par_force_rel;
    logic [AW-1:0] nxt_addr;
    bit            nxt_rel;

    // ---------------- timeline model ----------------
    int            m_occ;
    int            pub_q [$];
    bit            m_inpkt, m_pub;
    int            m_pid, m_first, m_last, m_disc;
    int            m_pkts, m_ovf, m_emp;
    bit            exp_rd_valid;
    logic [DW-1:0] exp_rd_word;

    task automatic drive_inputs();
        if (disp_active && !i_dispatch_packet_available) avail_start = cyc;
        i_dispatch_packet_available = disp_active;
        if (disp_active && rd_ptr < plen[disp_idx]) begin
            i_dispatch_fifo_empty   = 1'b0;
            i_dispatch_fifo_rd_data = pw[disp_idx][rd_ptr];
        end else begin
            i_dispatch_fifo_empty   = 1'b1;
            i_dispatch_fifo_rd_data = {$urandom, $urandom};
        end
        i_dispatch_data_valid = disp_active ? pval[disp_idx] : 8'h00;
        i_rd_addr     = nxt_addr;
        i_pkt_release = nxt_rel;
    endtask

    task automatic model_cycle();
        bit exp_rden, exp_disc, exp_busy;
        // Packet completion becomes visible in its discard cycle.
        if (m_inpkt && cyc == m_disc) begin
            if (m_pub) begin
                pub_q.push_back(m_pid);
                m_occ++;
                m_pkts++;
            end else if (plen[m_pid] == 0) m_emp++;
            else m_ovf++;
        end
        exp_rden = m_inpkt && cyc >= m_first && cyc <= m_last;
        exp_disc = m_inpkt && cyc == m_disc;
        exp_busy = m_inpkt || m_occ == 2;
        check("rd_en",   64'(o_dispatch_fifo_rd_en), 64'(exp_rden));
        check("discard", 64'(o_dispatch_packet_read_discard), 64'(exp_disc));
        check("busy",    64'(o_busy), 64'(exp_busy));
        check("ready",   64'(o_pkt_ready), 64'(m_occ > 0));
        if (m_occ > 0) check("pkt_bytes", 64'(o_pkt_bytes), 64'(pbytes(pub_q[0])));
        if (exp_rd_valid) check("rd_data", o_rd_data, exp_rd_word);
        if (exp_disc) begin
            check("stat_packets",   64'(o_stat_packets),   STATS ? 64'(m_pkts) : 64'd0);
            check("stat_overflows", 64'(o_stat_overflows), STATS ? 64'(m_ovf)  : 64'd0);
            check("stat_empty",     64'(o_stat_empty),     STATS ? 64'(m_emp)  : 64'd0);
        end
        // Read issued this cycle returns next cycle from the ready bank.
        exp_rd_valid = 1'b0;
        if (m_occ > 0 && int'(i_rd_addr) < plen[pub_q[0]]) begin
            exp_rd_valid = 1'b1;
            exp_rd_word  = pw[pub_q[0]][i_rd_addr];
        end
        if (exp_disc) m_inpkt = 1'b0;
        else if (!m_inpkt && i_dispatch_packet_available && m_occ < 2) begin
            m_inpkt = 1'b1;
            m_pid   = disp_idx;
            m_first = cyc + 1;
            m_last  = cyc + plen[disp_idx];
            m_disc  = (plen[disp_idx] == 0) ? cyc + 1 : cyc + plen[disp_idx] + 2;
            m_pub   = plen[disp_idx] > 0 && plen[disp_idx] <= DEPTH;
        end
        if (i_pkt_release && m_occ > 0) begin
            void'(pub_q.pop_front());
            m_occ--;
        end
    endtask

    task automatic env_update();
        if (o_dispatch_fifo_rd_en) begin
            rd_ptr++;
            pop_count++;
        end
        if (o_dispatch_packet_read_discard && disp_active) begin
            last_disc   = cyc;
            disp_active = 1'b0;
            disp_idx++;
            rd_ptr      = 0;
            gap         = $urandom_range(1, 3);
        end else if (!disp_active) begin
            if (gap > 0) gap--;
            if (gap == 0 && disp_idx < npkts) begin
                disp_active = 1'b1;
                rd_ptr      = 0;
            end
        end
        nxt_addr      = (par_fixed_addr >= 0) ? AW'(par_fixed_addr) : AW'($urandom % DEPTH);
        nxt_rel       = par_force_rel || (($urandom % 100) < par_rel_pct);
        par_force_rel = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        drive_inputs();
        @(negedge clk);
        model_cycle();
        env_update();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        i_areset = 1'b1;
        #1;
        check("rst_rd_data", o_rd_data, 64'd0);
        check("rst_busy",    64'(o_busy), 64'd0);
        check("rst_discard", 64'(o_dispatch_packet_read_discard), 64'd0);
        check("rst_ready",   64'(o_pkt_ready), 64'd0);
        check("rst_bytes",   64'(o_pkt_bytes), 64'd0);
        check("rst_rd_en",   64'(o_dispatch_fifo_rd_en), 64'd0);
        check("rst_stats",   64'(o_stat_packets | o_stat_overflows | o_stat_empty), 64'd0);
        i_dispatch_packet_available = 1'b0;
        i_dispatch_fifo_empty       = 1'b1;
        i_dispatch_fifo_rd_data     = '0;
        i_dispatch_data_valid       = '0;
        i_rd_addr                   = '0;
        i_pkt_release               = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        npkts = 0; disp_active = 0; gap = 1; rd_ptr = 0; disp_idx = 0;
        pop_count = 0; avail_start = 0; last_disc = 0;
        par_rel_pct = 0; par_fixed_addr = -1; par_force_rel = 0;
        nxt_addr = '0; nxt_rel = 0;
        m_occ = 0; pub_q.delete(); m_inpkt = 0; m_pub = 0;
        m_pkts = 0; m_ovf = 0; m_emp = 0; exp_rd_valid = 0;
        i_areset = 1'b0;
    endtask

    initial begin
        int p0, guard;
        i_areset = 1'b0;
        #2;
        // ---- 3-word packet, valid 1f ----
        do_reset();
        add_pkt(3, 8'h1f, 64'hA000_0000_0000_0001);
        par_fixed_addr = 2;
        run(8);
        check("A_latency", 64'(last_disc - avail_start), 64'd5);
        check("A_ready", 64'(o_pkt_ready), 64'd1);
        check("A_bytes", 64'(o_pkt_bytes), 64'd21);
        check("A_rd_addr2", o_rd_data, 64'hA000_0000_0000_0003);

        // ---- two packets fill both banks, third waits ----
        do_reset();
        add_pkt(2, 8'hff, 64'd0);
        add_pkt(2, 8'h01, 64'd0);
        add_pkt(3, 8'h0f, 64'd0);
        run(20);
        p0 = pop_count;
        run(10);
        check("B_no_pop", 64'(pop_count - p0), 64'd0);
        check("B_pops", 64'(pop_count), 64'd4);
        check("B_busy", 64'(o_busy), 64'd1);
        check("B_bytes0", 64'(o_pkt_bytes), 64'd16);
        par_force_rel = 1'b1;
        run(2);
        run(15);
        check("B_bytes1", 64'(o_pkt_bytes), 64'd9);
        check("B_pops3", 64'(pop_count), 64'd7);
        par_force_rel = 1'b1;
        run(3);
        check("B_bytes2", 64'(o_pkt_bytes), 64'd20);

        // ---- 17-word packet overflows ----
        do_reset();
        add_pkt(17, 8'hff, 64'd0);
        run(25);
        check("C_pops", 64'(pop_count), 64'd17);
        check("C_latency", 64'(last_disc - avail_start), 64'd19);
        check("C_ready", 64'(o_pkt_ready), 64'd0);
        check("C_ovf", 64'(o_stat_overflows), STATS ? 64'd1 : 64'd0);

        // ---- exactly 16 words ----
        do_reset();
        add_pkt(16, 8'hff, 64'd0);
        run(22);
        check("D_ready", 64'(o_pkt_ready), 64'd1);
        check("D_bytes", 64'(o_pkt_bytes), 64'd128);

        // ---- empty packet ----
        do_reset();
        add_pkt(0, 8'h00, 64'd0);
        run(5);
        check("E_latency", 64'(last_disc - avail_start), 64'd1);
        check("E_ready", 64'(o_pkt_ready), 64'd0);
        check("E_pops", 64'(pop_count), 64'd0);
        check("E_empty", 64'(o_stat_empty), STATS ? 64'd1 : 64'd0);

        // ---- reset in the middle of COPY ----
        do_reset();
        add_pkt(10, 8'hff, 64'd0);
        run(5);
        check("F_pops_mid", 64'(pop_count), 64'd3);
        #2;
        do_reset();
        add_pkt(1, 8'h01, 64'd0);
        run(6);
        check("F_ready", 64'(o_pkt_ready), 64'd1);
        check("F_bytes", 64'(o_pkt_bytes), 64'd1);

        // ---- randomized traffic, two release rates ----
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            par_rel_pct = (ph == 0) ? 25 : 80;
            for (int i = 0; i < 40; i++) begin
                int r, len;
                r = $urandom % 10;
                if (r == 0) len = 0;
                else if (r == 1) len = $urandom_range(DEPTH + 1, DEPTH + 4);
                else len = $urandom_range(1, DEPTH);
                add_pkt(len, 8'hff >> ($urandom % 8), 64'd0);
            end
            guard = 0;
            while (!(disp_idx >= npkts && !m_inpkt) && guard < 5000) begin
                step();
                guard++;
            end
            check("random_done", 64'(guard < 5000), 64'd1);
            run(20);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
